// File: rtl/capacitive_sensor_array.sv
// Capacitive touch scanner for an RC-charge sensor array.
// The block charges one channel at a time through sensor_out and counts
// clocks until the synchronised sensor_in sees the pin cross its input
// threshold. It then holds the charge for a settle period and discharges
// before moving to the next channel. Each completed measurement latches a
// count, a touched flag (count > threshold) and a timeout flag for that
// channel only.
module capacitive_sensor_array #(
   parameter int NUM_CH           = 4,
   parameter int COUNT_W          = 16,
   parameter int SETTLE_CYCLES    = 5000,
   parameter int DISCHARGE_CYCLES = 5000,
   parameter int TIMEOUT          = 65535
) (
   input  logic                        clock,
   input  logic                        resetn,
   input  logic                        start,
   input  logic                        continuous,
   input  logic [COUNT_W-1:0]          threshold,
   input  logic [NUM_CH-1:0]           sensor_in,
   output logic [NUM_CH-1:0]           sensor_out,
   output logic [NUM_CH*COUNT_W-1:0]   final_count_out,
   output logic [COUNT_W-1:0]          count_out,
   output logic [NUM_CH-1:0]           touched,
   output logic [NUM_CH-1:0]           timeout_flag,
   output logic                        busy,
   output logic                        done
);

   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TMAX      = (SETTLE_CYCLES > DISCHARGE_CYCLES) ? SETTLE_CYCLES : DISCHARGE_CYCLES;
   localparam int TIMER_W   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

   localparam logic [COUNT_W-1:0] TIMEOUT_C    = COUNT_W'(TIMEOUT);
   localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] DISCH_LAST   = TIMER_W'(DISCHARGE_CYCLES - 1);
   localparam logic [CH_W-1:0]    LAST_CH      = CH_W'(NUM_CH - 1);
   localparam logic [NUM_CH-1:0]  ONE_HOT0     = NUM_CH'(1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHARGE    = 3'd1,
      SETTLE    = 3'd2,
      DISCHARGE = 3'd3,
      NEXT      = 3'd4
   } state_t;

   state_t                      state_q;
   logic [CH_W-1:0]             ch_q;
   logic [COUNT_W-1:0]          cnt_q;
   logic [TIMER_W-1:0]          timer_q;
   logic [NUM_CH-1:0]           sync1_q;
   logic [NUM_CH-1:0]           sync2_q;
   logic [NUM_CH-1:0]           sensor_out_q;
   logic [NUM_CH*COUNT_W-1:0]   final_q;
   logic [NUM_CH-1:0]           touched_q;
   logic [NUM_CH-1:0]           timeout_q;
   logic                        done_q;

   // Two-flop synchroniser on every receive pin; the pins are asynchronous.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sensor_in;
         sync2_q <= sync1_q;
      end
   end

   // Scan sequencer: walks the channels, measures, latches and paces the
   // settle/discharge phases. All pin drives and flags are registered here.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         ch_q         <= '0;
         cnt_q        <= '0;
         timer_q      <= '0;
         sensor_out_q <= '0;
         final_q      <= '0;
         touched_q    <= '0;
         timeout_q    <= '0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  ch_q         <= '0;
                  cnt_q        <= '0;
                  sensor_out_q <= ONE_HOT0;
                  state_q      <= CHARGE;
               end
            end
            CHARGE: begin
               // A detected edge wins over a simultaneous ceiling hit: the
               // measurement is real, so it is not reported as a timeout.
               if (sync2_q[ch_q]) begin
                  final_q[ch_q*COUNT_W +: COUNT_W] <= cnt_q;
                  timeout_q[ch_q] <= 1'b0;
                  touched_q[ch_q] <= (cnt_q > threshold);
                  timer_q         <= '0;
                  state_q         <= SETTLE;
               end else if (cnt_q == TIMEOUT_C) begin
                  final_q[ch_q*COUNT_W +: COUNT_W] <= TIMEOUT_C;
                  timeout_q[ch_q] <= 1'b1;
                  touched_q[ch_q] <= 1'b0;
                  sensor_out_q    <= '0;
                  timer_q         <= '0;
                  state_q         <= DISCHARGE;
               end else begin
                  cnt_q <= cnt_q + COUNT_W'(1);
               end
            end
            SETTLE: begin
               if (timer_q == SETTLE_LAST) begin
                  timer_q      <= '0;
                  sensor_out_q <= '0;
                  state_q      <= DISCHARGE;
               end else begin
                  timer_q <= timer_q + TIMER_W'(1);
               end
            end
            DISCHARGE: begin
               if (timer_q == DISCH_LAST) begin
                  timer_q <= '0;
                  state_q <= NEXT;
               end else begin
                  timer_q <= timer_q + TIMER_W'(1);
               end
            end
            NEXT: begin
               cnt_q <= '0;
               if (ch_q != LAST_CH) begin
                  ch_q         <= ch_q + CH_W'(1);
                  sensor_out_q <= ONE_HOT0 << (ch_q + CH_W'(1));
                  state_q      <= CHARGE;
               end else begin
                  done_q <= 1'b1;
                  if (continuous) begin
                     ch_q         <= '0;
                     sensor_out_q <= ONE_HOT0;
                     state_q      <= CHARGE;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q      <= IDLE;
               sensor_out_q <= '0;
            end
         endcase
      end
   end

   assign sensor_out      = sensor_out_q;
   assign final_count_out = final_q;
   assign count_out       = cnt_q;
   assign touched         = touched_q;
   assign timeout_flag    = timeout_q;
   assign busy            = (state_q != IDLE);
   assign done            = done_q;

endmodule

// File: doc/capacitive_sensor_array.md
CAPACITIVE_SENSOR_ARRAY -- requirements
Module: capacitive_sensor_array

Interface
REQ-001 SHALL take parameter NUM_CH, default 4: number of sensor channels, 1..16.
REQ-002 SHALL take parameter COUNT_W, default 16: width of each per-channel count.
REQ-003 SHALL take parameter SETTLE_CYCLES, default 5000: hold cycles after charge detect, so the capacitor is fully charged (100 us at 50 MHz).
REQ-004 SHALL take parameter DISCHARGE_CYCLES, default 5000: cycles sensor_out is held low before the next channel.
REQ-005 SHALL take parameter TIMEOUT, default 65535: charge-count ceiling, at most 2^COUNT_W-1.
REQ-006 SHALL have port clock, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1: level-sampled scan request.
REQ-009 SHALL have port continuous, input, 1: when high, rescan automatically.
REQ-010 SHALL have port threshold, input, COUNT_W: touch threshold.
REQ-011 SHALL have port sensor_in, input, NUM_CH: asynchronous receive pins.
REQ-012 SHALL have port sensor_out, output, NUM_CH: charge drive pins.
REQ-013 SHALL have port final_count_out, output, NUM_CH*COUNT_W: latched counts, channel i at bits [i*COUNT_W +: COUNT_W].
REQ-014 SHALL have port count_out, output, COUNT_W: live counter of the active channel.
REQ-015 SHALL have port touched, output, NUM_CH: per-channel final count > threshold.
REQ-016 SHALL have port timeout_flag, output, NUM_CH: per-channel timeout from the last measurement.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle pulse at end of scan.

Function
REQ-019 SHALL pass each sensor_in bit through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-020 SHALL implement FSM states IDLE, CHARGE, SETTLE, DISCHARGE, NEXT.
REQ-021 SHALL, in IDLE with start=1, set ch=0, clear the counter and enter CHARGE next cycle; start is ignored when not IDLE.
REQ-022 SHALL, in CHARGE, drive sensor_out[ch]=1 (all other bits 0) and increment the counter by 1 per cycle while synchronised sensor_in[ch]=0.
REQ-023 SHALL, in CHARGE when synchronised sensor_in[ch]=1, latch the counter into slice ch, clear timeout_flag[ch], update touched[ch], and enter SETTLE; the count includes the 2-cycle synchroniser latency.
REQ-024 SHALL, in CHARGE when the counter equals TIMEOUT, latch TIMEOUT, set timeout_flag[ch], set touched[ch]=0 and enter DISCHARGE; the counter never wraps.
REQ-025 SHALL, in SETTLE, keep sensor_out[ch]=1 for exactly SETTLE_CYCLES cycles, then enter DISCHARGE.
REQ-026 SHALL, in DISCHARGE, drive sensor_out to all zeros for exactly DISCHARGE_CYCLES cycles, then enter NEXT.
REQ-027 SHALL, in NEXT, increment ch and enter CHARGE with the counter cleared if ch < NUM_CH-1.
REQ-028 SHALL, in NEXT when ch = NUM_CH-1, pulse done for one cycle and then either restart at ch=0 in CHARGE if continuous=1, or enter IDLE.
REQ-029 SHALL sample continuous only in NEXT on the last channel; clearing it mid-scan completes the current scan.
REQ-030 SHALL compute touched[ch] as an unsigned strict comparison, count > threshold, with threshold sampled at latch time.
REQ-031 SHALL update final_count_out, touched and timeout_flag only at latch events; other channels hold their values.
REQ-032 SHALL ensure a channel already high in the first CHARGE cycle latches count 0 or 1 (synchroniser history); no special case is required.

Reset
REQ-033 SHALL, on resetn=0, immediately force IDLE, ch=0, counter=0, synchronisers=0, sensor_out=0, final_count_out=0, touched=0, timeout_flag=0, busy=0 and done=0, including when reset is asserted mid-scan.
REQ-034 SHALL leave reset synchronously on the first clock edge after resetn deasserts and require a new start.

Verification
REQ-035 SHALL verify: NUM_CH=2, SETTLE/DISCHARGE=4, ch0 rises 10 cycles after CHARGE entry, threshold=5 -> slice0=10+sync latency, touched[0]=1, timeout_flag[0]=0.
REQ-036 SHALL verify: TIMEOUT=20, sensor_in[1] held 0 -> slice1=20, timeout_flag[1]=1, touched[1]=0, scan proceeds and done pulses once.
REQ-037 SHALL verify: start pulsed while busy -> ignored, with exactly one done per scan.
REQ-038 SHALL verify: continuous=1 -> back-to-back scans with done every scan; continuous cleared mid-scan -> one final done, then IDLE with busy=0.
REQ-039 SHALL verify: resetn low during SETTLE of ch1 -> all outputs 0 asynchronously; after release, start gives a full scan from ch0.
REQ-040 SHALL verify: sensor_out is one-hot or zero in every cycle, and all zeros throughout DISCHARGE.
